serial_addsub: RTL and testbench

//  Parametrised multi-cycle adder/subtractor processing operands LSB-first, BITS_PER_CYCLE bits per clock.

---
 rtl/serial_addsub_pkg.sv | 17 +
 rtl/addsub_cell.sv | 18 +
 rtl/serial_addsub.sv | 124 ++++++++++++
 tb/tb_serial_addsub.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared constants for the serial adder/subtractor: FSM encodings, mode values,
// and the counter-width helper.
package serial_addsub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // The chunk counter is always at least one bit wide, even when one chunk covers the operand.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addsub_cell.sv
// One-bit full adder/subtractor cell. In subtract mode, cin and cout carry the
// borrow instead of the carry.
module addsub_cell
  import serial_addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic out,
  output logic cout
);

  assign out  = x ^ y ^ cin;
  assign cout = (mode == MODE_SUB) ? ((~x & y) | (cin & ~(x ^ y)))
                                   : ((x & y) | (cin & (x ^ y)));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor that consumes the operands LSB-first, BITS_PER_CYCLE
// bits per clock. The carry or borrow is held in a flop between chunks.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       fsm_state
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             mode_q;
  logic             carry_q;
  logic             a_msb;
  logic             b_msb;

  logic [BITS_PER_CYCLE:0]   c;
  logic [BITS_PER_CYCLE-1:0] s;
  logic [WIDTH-1:0]          res_next;
  logic                      ovf_next;
  logic                      accept;
  logic                      last;

  assign c[0] = carry_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    addsub_cell u_cell (
      .x    (opa[i]),
      .y    (opb[i]),
      .cin  (c[i]),
      .mode (mode_q),
      .out  (s[i]),
      .cout (c[i+1])
    );
  end

  // The result bits enter opa at the top while operand bits leave at the bottom,
  // so after N chunks opa holds the complete result.
  if (WIDTH > BITS_PER_CYCLE) begin : g_res_shift
    assign res_next = {s, opa[WIDTH-1:BITS_PER_CYCLE]};
  end else begin : g_res_single
    assign res_next = s;
  end

  // The operand MSBs are saved at capture because the shift registers overwrite them.
  assign ovf_next = (mode_q == MODE_SUB)
                  ? ((a_msb != b_msb) && (res_next[WIDTH-1] != a_msb))
                  : ((a_msb == b_msb) && (res_next[WIDTH-1] != a_msb));

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            opa     <= a;
            opb     <= b;
            mode_q  <= mode;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            carry_q <= 1'b0;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa     <= res_next;
          opb     <= opb >> BITS_PER_CYCLE;
          carry_q <= c[BITS_PER_CYCLE];
          if (last) begin
            cnt    <= '0;
            state  <= DONE;
            result <= res_next;
            cout   <= c[BITS_PER_CYCLE];
            ovf    <= ovf_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub. It runs three configurations: 8/1, 8/4 and 16/1.
// Drivers push the expected {result, cout, ovf} values, and per-DUT monitors pop and compare on done.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        start8, start4, start16;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  result8;
  logic [1:0]  state8;
  logic        busy4, done4, cout4, ovf4;
  logic [7:0]  result4;
  logic [1:0]  state4;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] result16;
  logic [1:0]  state16;

  int checks = 0;
  int fails  = 0;

  logic [9:0]  exp8_q[$];
  logic [9:0]  exp4_q[$];
  logic [17:0] exp16_q[$];

  // Clock and DUTs.
  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8),
    .fsm_state(state8)
  );

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .a(a[7:0]), .b(b[7:0]),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4),
    .fsm_state(state4)
  );

  serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode), .a(a), .b(b),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16), .ovf(ovf16),
    .fsm_state(state16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done8 : (sel == 1) ? done4 : done16;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy8 : (sel == 1) ? busy4 : busy16;
  endfunction

  // Reference model for the 16-bit random vectors: plain integer arithmetic.
  function automatic logic [17:0] model16(input logic m, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    int sx, sy, sr;
    logic o;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (m) begin
      s  = {1'b0, x} - {1'b0, y};
      sr = sx - sy;
    end else begin
      s  = {1'b0, x} + {1'b0, y};
      sr = sx + sy;
    end
    o = (sr > 32767) || (sr < -32768);
    return {s[15:0], s[16], o};
  endfunction

  // Scoreboard monitors.
  always @(negedge clk) begin : mon8
    logic [9:0] e;
    if (done8 === 1'b1) begin
      if (exp8_q.size() == 0) check("dut8 done with nothing pending", 32'(done8), 32'd0);
      else begin
        e = exp8_q.pop_front();
        check("dut8 result", 32'(result8), 32'(e[9:2]));
        check("dut8 cout", 32'(cout8), 32'(e[1]));
        check("dut8 ovf", 32'(ovf8), 32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin : mon4
    logic [9:0] e;
    if (done4 === 1'b1) begin
      if (exp4_q.size() == 0) check("dut4 done with nothing pending", 32'(done4), 32'd0);
      else begin
        e = exp4_q.pop_front();
        check("dut4 result", 32'(result4), 32'(e[9:2]));
        check("dut4 cout", 32'(cout4), 32'(e[1]));
        check("dut4 ovf", 32'(ovf4), 32'(e[0]));
      end
    end
  end

  always @(negedge clk) begin : mon16
    logic [17:0] e;
    if (done16 === 1'b1) begin
      if (exp16_q.size() == 0) check("dut16 done with nothing pending", 32'(done16), 32'd0);
      else begin
        e = exp16_q.pop_front();
        check("dut16 result", 32'(result16), 32'(e[17:2]));
        check("dut16 cout", 32'(cout16), 32'(e[1]));
        check("dut16 ovf", 32'(ovf16), 32'(e[0]));
      end
    end
  end

  // Driver: start for one cycle, push the expectation, then time the run until done.
  task automatic run_op(input int sel, input logic m, input logic [15:0] x, input logic [15:0] y,
                        input logic [17:0] e, input int lat);
    int cyc;
    int bcnt;
    @(negedge clk);
    mode = m;
    a    = x;
    b    = y;
    case (sel)
      0:       begin start8  = 1'b1; exp8_q.push_back(e[9:0]); end
      1:       begin start4  = 1'b1; exp4_q.push_back(e[9:0]); end
      default: begin start16 = 1'b1; exp16_q.push_back(e);     end
    endcase
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start4  = 1'b0;
    start16 = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!done_of(sel) && cyc < 64) begin
      if (busy_of(sel)) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check($sformatf("latency dut%0d", sel), 32'(cyc), 32'(lat));
    check($sformatf("busy cycles dut%0d", sel), 32'(bcnt), 32'(lat));
  endtask

  initial begin : stim
    int seen;
    int cyc;
    logic [15:0] rx, ry;
    logic        rm;

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset busy", 32'({busy8, busy4, busy16}), 32'd0);
    check("reset done", 32'({done8, done4, done16}), 32'd0);
    check("reset result8", 32'(result8), 32'd0);
    check("reset result16", 32'(result16), 32'd0);
    check("reset flags", 32'({cout8, ovf8, cout16, ovf16}), 32'd0);
    check("reset state", 32'({state8, state4, state16}), 32'd0);

    // Basic add, then verify the one-cycle done pulse and that the result holds in IDLE.
    run_op(0, 1'b0, 16'h35, 16'h4A, {8'h7F, 1'b0, 1'b0}, 8);
    @(posedge clk); #1;
    check("done is one cycle", 32'(done8), 32'd0);
    check("idle after done", 32'(state8), 32'd0);
    check("result held in idle", 32'(result8), 32'h7F);

    // Carry and overflow corners, then back-to-back operations from DONE.
    run_op(0, 1'b0, 16'hFF, 16'h01, {8'h00, 1'b1, 1'b0}, 8);
    run_op(0, 1'b0, 16'h7F, 16'h01, {8'h80, 1'b0, 1'b1}, 8);
    run_op(0, 1'b1, 16'h10, 16'h20, {8'hF0, 1'b1, 1'b0}, 8);
    run_op(0, 1'b1, 16'h80, 16'h01, {8'h7F, 1'b0, 1'b1}, 8);
    run_op(0, 1'b1, 16'h05, 16'h05, {8'h00, 1'b0, 1'b0}, 8);
    run_op(0, 1'b0, 16'h80, 16'h80, {8'h00, 1'b1, 1'b1}, 8);

    // A start pulse and operand changes mid-RUN must be ignored.
    @(negedge clk);
    mode = 1'b0; a = 16'h12; b = 16'h34; start8 = 1'b1;
    exp8_q.push_back({8'h46, 1'b0, 1'b0});
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mode = 1'b1; a = 16'hFF; b = 16'hFF; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    check("busy mid-run", 32'(busy8), 32'd1);
    check("result held during run", 32'(result8), 32'h00);
    cyc = 0;
    while (!done8 && cyc < 32) begin @(posedge clk); #1; cyc++; end
    check("mid-run op finished", 32'(done8), 32'd1);
    @(posedge clk); #1;
    check("no queued op after ignored start", 32'(busy8), 32'd0);

    // Reset during cycle 4 of RUN aborts the operation.
    @(negedge clk);
    mode = 1'b0; a = 16'h55; b = 16'h11; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort result", 32'(result8), 32'd0);
    check("abort state", 32'(state8), 32'd0);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) seen++; end
    check("no done after abort", 32'(seen), 32'd0);

    // Four bits per cycle.
    run_op(1, 1'b0, 16'hF0, 16'h1F, {8'h0F, 1'b1, 1'b0}, 2);
    run_op(1, 1'b1, 16'h3C, 16'hC3, {8'h79, 1'b1, 1'b0}, 2);
    run_op(1, 1'b1, 16'h7F, 16'h80, {8'hFF, 1'b1, 1'b1}, 2);

    // 16-bit width: directed corners, then random vectors against the model.
    run_op(2, 1'b0, 16'h1234, 16'hEDCC, {16'h0000, 1'b1, 1'b0}, 16);
    run_op(2, 1'b0, 16'h7FFF, 16'h0001, {16'h8000, 1'b0, 1'b1}, 16);
    run_op(2, 1'b1, 16'h0000, 16'h0001, {16'hFFFF, 1'b1, 1'b0}, 16);
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(0, 65535));
      rm = 1'($urandom_range(0, 1));
      run_op(2, rm, rx, ry, model16(rm, rx, ry), 16);
    end

    repeat (3) @(posedge clk); #1;
    check("exp8 queue drained", 32'(exp8_q.size()), 32'd0);
    check("exp4 queue drained", 32'(exp4_q.size()), 32'd0);
    check("exp16 queue drained", 32'(exp16_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
